// File: rtl/cp2_cmd_sequencer.sv
// CP2 (GTE) command issue/sequencing controller: per-opcode latency, start/commit strobes, register interlock.
// Optional cycle statistics are enabled by defining CP2_CYCLE_STATS_EN.
module cp2_cmd_sequencer #(
  parameter int CNT_W   = 6,
  parameter int DEF_LAT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [5:0]  cmd_funct,
  input  logic        cmd_sf,
  input  logic        cmd_lm,
  input  logic        issue_hold,
  input  logic        reg_access,
  output logic        cmd_ready,
  output logic        CP2_free,
  output logic        reg_stall,
  output logic        gte_start,
  output logic [5:0]  gte_op,
  output logic        gte_sf,
  output logic        gte_lm,
  output logic        gte_commit,
  output logic        illegal_op,
  output logic [31:0] busy_cycles,
  output logic [31:0] cmd_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op_q, op_d;
  logic             sf_q, sf_d, lm_q, lm_d;
  logic             start_q, start_d, illegal_q, illegal_d;
  logic [CNT_W-1:0] lat_lu;
  logic             accept;

  // Zero marks an undefined function code; no defined command has latency 0.
  function automatic logic [CNT_W-1:0] lat_lookup(input logic [5:0] f);
    case (f)
      6'h01: lat_lookup = CNT_W'(15);
      6'h06: lat_lookup = CNT_W'(8);
      6'h0C: lat_lookup = CNT_W'(6);
      6'h10, 6'h11, 6'h12: lat_lookup = CNT_W'(8);
      6'h13: lat_lookup = CNT_W'(19);
      6'h14: lat_lookup = CNT_W'(13);
      6'h16: lat_lookup = CNT_W'(44);
      6'h1B: lat_lookup = CNT_W'(17);
      6'h1C: lat_lookup = CNT_W'(11);
      6'h1E: lat_lookup = CNT_W'(14);
      6'h20: lat_lookup = CNT_W'(30);
      6'h28: lat_lookup = CNT_W'(5);
      6'h29: lat_lookup = CNT_W'(8);
      6'h2A: lat_lookup = CNT_W'(17);
      6'h2D: lat_lookup = CNT_W'(5);
      6'h2E: lat_lookup = CNT_W'(6);
      6'h30: lat_lookup = CNT_W'(23);
      6'h3D, 6'h3E: lat_lookup = CNT_W'(5);
      6'h3F: lat_lookup = CNT_W'(39);
      default: lat_lookup = '0;
    endcase
  endfunction

  assign lat_lu = lat_lookup(cmd_funct);
  assign accept = cmd_valid & (state_q == IDLE) & ~issue_hold;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sf_d      = sf_q;
    lm_d      = lm_q;
    start_d   = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = cmd_funct;
          sf_d    = cmd_sf;
          lm_d    = cmd_lm;
          start_d = 1'b1;
          state_d = RUN;
          if (lat_lu == '0) begin
            cnt_d     = CNT_W'(DEF_LAT);
            illegal_d = 1'b1;
          end else begin
            cnt_d = lat_lu;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      sf_q      <= 1'b0;
      lm_q      <= 1'b0;
      start_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sf_q      <= sf_d;
      lm_q      <= lm_d;
      start_q   <= start_d;
      illegal_q <= illegal_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign CP2_free   = (state_q == IDLE);
  // Combinational on purpose: an access in the DONE cycle still waits for the commit.
  assign reg_stall  = reg_access & (state_q != IDLE);
  assign gte_start  = start_q;
  assign illegal_op = illegal_q;
  assign gte_commit = (state_q == DONE);
  assign gte_op     = op_q;
  assign gte_sf     = sf_q;
  assign gte_lm     = lm_q;

`ifdef CP2_CYCLE_STATS_EN
  logic [31:0] busy_q, busy_d, ccount_q, ccount_d;

  always_comb begin
    busy_d   = busy_q;
    ccount_d = ccount_q;
    if (state_q != IDLE) busy_d = busy_q + 32'd1;
    if (accept) ccount_d = ccount_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= '0;
      ccount_q <= '0;
    end else begin
      busy_q   <= busy_d;
      ccount_q <= ccount_d;
    end
  end

  assign busy_cycles = busy_q;
  assign cmd_count   = ccount_q;
`else
  assign busy_cycles = 32'd0;
  assign cmd_count   = 32'd0;
`endif

endmodule

// File: tb/tb_cp2_cmd_sequencer.sv
// Directed bench for cp2_cmd_sequencer: queued expectations are popped and compared as the DUT responds.
module tb_cp2_cmd_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [5:0]  cmd_funct = '0;
  logic        cmd_sf = 1'b0;
  logic        cmd_lm = 1'b0;
  logic        issue_hold = 1'b0;
  logic        reg_access = 1'b0;
  logic        cmd_ready, CP2_free, reg_stall, gte_start, gte_sf, gte_lm;
  logic        gte_commit, illegal_op;
  logic [5:0]  gte_op;
  logic [31:0] busy_cycles, cmd_count;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  typedef struct {
    logic [5:0] op;
    logic       sf;
    logic       lm;
    logic       ill;
    int         lat;
  } exp_t;

  exp_t sb[$];

  cp2_cmd_sequencer dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_funct(cmd_funct),
    .cmd_sf(cmd_sf), .cmd_lm(cmd_lm), .issue_hold(issue_hold), .reg_access(reg_access),
    .cmd_ready(cmd_ready), .CP2_free(CP2_free), .reg_stall(reg_stall), .gte_start(gte_start),
    .gte_op(gte_op), .gte_sf(gte_sf), .gte_lm(gte_lm), .gte_commit(gte_commit),
    .illegal_op(illegal_op), .busy_cycles(busy_cycles), .cmd_count(cmd_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drive one command (optionally held off for hold_cyc cycles) and follow it to IDLE.
  task automatic do_cmd(input logic [5:0] f, input logic sf, input logic lm,
                        input int lat, input logic ill, input int hold_cyc);
    exp_t e;
    int busy, ncommit, commit_at, nstart, nill, nstall;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_funct = f; cmd_sf = sf; cmd_lm = lm;
    issue_hold = (hold_cyc > 0);
    sb.push_back('{op: f, sf: sf, lm: lm, ill: ill, lat: lat});
    for (int k = 0; k < hold_cyc; k++) begin
      @(negedge clock);
      check("hold_no_start", gte_start, 0);
      check("hold_free", CP2_free, 1);
    end
    issue_hold = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0;
    e = sb.pop_front();
    check("start", gte_start, 1);
    check("op", gte_op, e.op);
    check("sf", gte_sf, e.sf);
    check("lm", gte_lm, e.lm);
    check("illegal_with_start", illegal_op, e.ill);
    busy = 0; ncommit = 0; commit_at = -1; nstart = 0; nill = 0; nstall = 0;
    for (int i = 0; i < 120; i++) begin
      if (CP2_free) break;
      busy++;
      if (gte_start) nstart++;
      if (illegal_op) nill++;
      if (reg_stall) nstall++;
      if (gte_commit) begin ncommit++; commit_at = busy; end
      @(negedge clock);
    end
    check("busy_len", busy, e.lat + 1);
    check("commit_count", ncommit, 1);
    check("commit_pos", commit_at, e.lat + 1);
    check("start_pulses", nstart, 1);
    check("illegal_pulses", nill, e.ill ? 1 : 0);
    check("stall_cycles", nstall, reg_access ? e.lat + 1 : 0);
    check("idle_ready", cmd_ready, 1);
    check("idle_stall", reg_stall, 0);
  endtask

  initial begin
    exp_t e;
    int s1, found, ncommit;

    repeat (3) @(negedge clock);
    check("rst_free", CP2_free, 1);
    check("rst_ready", cmd_ready, 1);
    check("rst_stall", reg_stall, 0);
    check("rst_start", gte_start, 0);
    check("rst_commit", gte_commit, 0);
    check("rst_illegal", illegal_op, 0);
    check("rst_op", {gte_op, gte_sf, gte_lm}, 0);
    check("rst_busy_cycles", busy_cycles, 0);
    check("rst_cmd_count", cmd_count, 0);
    reset_n = 1'b1;

    // RTPS
    do_cmd(6'h01, 1'b1, 1'b0, 15, 1'b0, 0);

    // NCDT with a follow-up command held on cmd_valid
    @(negedge clock);
    cmd_valid = 1'b1; cmd_funct = 6'h16; cmd_sf = 1'b0; cmd_lm = 1'b1;
    sb.push_back('{op: 6'h16, sf: 1'b0, lm: 1'b1, ill: 1'b0, lat: 44});
    @(negedge clock);
    e = sb.pop_front();
    check("ncdt_start", gte_start, 1);
    check("ncdt_op", gte_op, e.op);
    check("ncdt_lm", gte_lm, e.lm);
    check("ncdt_ready_low", cmd_ready, 0);
    s1 = cyc;
    cmd_funct = 6'h28; cmd_sf = 1'b1; cmd_lm = 1'b0;
    sb.push_back('{op: 6'h28, sf: 1'b1, lm: 1'b0, ill: 1'b0, lat: 5});
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (gte_start) begin found = 1; break; end
    end
    cmd_valid = 1'b0;
    e = sb.pop_front();
    check("second_start_seen", found, 1);
    check("second_start_gap", cyc - s1, 46);
    check("second_op", gte_op, e.op);
    check("second_sf", gte_sf, e.sf);
    for (int i = 0; i < 20; i++) begin
      if (CP2_free) break;
      @(negedge clock);
    end
    check("second_done", CP2_free, 1);

    // SQR with a register access pending
    reg_access = 1'b1;
    do_cmd(6'h28, 1'b0, 1'b1, 5, 1'b0, 0);
    reg_access = 1'b0;

    // issue_hold blocks acceptance for three cycles
    do_cmd(6'h0C, 1'b1, 1'b1, 6, 1'b0, 3);

    // undefined function code
    do_cmd(6'h05, 1'b0, 1'b0, 2, 1'b1, 0);
    do_cmd(6'h3F, 1'b1, 1'b0, 39, 1'b0, 0);

    // reset during RTPT
    @(negedge clock);
    cmd_valid = 1'b1; cmd_funct = 6'h30;
    @(negedge clock);
    cmd_valid = 1'b0;
    check("rtpt_start", gte_start, 1);
    repeat (5) @(negedge clock);
    check("rtpt_busy", CP2_free, 0);
    #2 reset_n = 1'b0;
    #1;
    check("abort_free", CP2_free, 1);
    check("abort_ready", cmd_ready, 1);
    check("abort_commit", gte_commit, 0);
    check("abort_op", gte_op, 0);
    check("abort_busy_cycles", busy_cycles, 0);
    check("abort_cmd_count", cmd_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    ncommit = 0;
    repeat (30) begin
      @(negedge clock);
      if (gte_commit || gte_start) ncommit++;
    end
    check("abort_no_commit", ncommit, 0);
    check("abort_idle", CP2_free, 1);

    // statistics over two SQRs
    do_cmd(6'h28, 1'b0, 1'b0, 5, 1'b0, 0);
    do_cmd(6'h28, 1'b0, 1'b0, 5, 1'b0, 0);
`ifdef CP2_CYCLE_STATS_EN
    check("stats_cmd_count", cmd_count, 2);
    check("stats_busy_cycles", busy_cycles, 12);
`else
    check("stats_cmd_count", cmd_count, 0);
    check("stats_busy_cycles", busy_cycles, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
